// File: rtl/branch_resolve.sv
// Branch resolution queue: tracks predicted directions until execute resolves them.
// Optional saturating mispredict counter enabled by BRANCH_RESOLVE_MISPREDICT_COUNT_EN.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic            pred_taken,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            update,
  output logic            taken,
  output logic            mispredict,
  output logic            empty,
  output logic            full,
  output logic            res_err,
  output logic [CNTW-1:0] mispredict_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DEPTH-1:0] q;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             head;
  logic             push;
  logic             pop;
  logic             miss;

  // Extra MSB on the pointers separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pred_ready = !full;
  assign head = q[rd_ptr[AW-1:0]];
  assign push = pred_valid && pred_ready;
  assign pop  = res_valid && !empty;
  assign miss = pop && (res_taken != head);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (miss) begin
      // Wrong path: drop every younger entry and any same-cycle push.
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        q[wr_ptr[AW-1:0]] <= pred_taken;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update     <= 1'b0;
      taken      <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      update     <= pop;
      taken      <= pop && res_taken;
      mispredict <= miss;
      if (res_valid && empty) begin
        res_err <= 1'b1;
      end
    end
  end

`ifdef BRANCH_RESOLVE_MISPREDICT_COUNT_EN
  localparam logic [CNTW-1:0] CNT_ONE = 1;

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (mispredict && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign mispredict_count = cnt;
`else
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: queue-based reference model,
// directed scenarios with literal expectations and randomized traffic.
module tb_branch_resolve;

  localparam int DEPTH = 4;
  localparam int CNTW  = 8;
  localparam int CMAX  = (1 << CNTW) - 1;
`ifdef BRANCH_RESOLVE_MISPREDICT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            pred_valid;
  logic            pred_taken;
  logic            pred_ready;
  logic            res_valid;
  logic            res_taken;
  logic            update;
  logic            taken;
  logic            mispredict;
  logic            empty;
  logic            full;
  logic            res_err;
  logic [CNTW-1:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  branch_resolve #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .pred_ready       (pred_ready),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .update           (update),
    .taken            (taken),
    .mispredict       (mispredict),
    .empty            (empty),
    .full             (full),
    .res_err          (res_err),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding predictions as a plain queue.
  bit mq[$];
  bit exp_update, exp_taken, exp_mis, exp_err;
  int exp_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_update = 0;
      exp_taken  = 0;
      exp_mis    = 0;
      exp_err    = 0;
      exp_cnt    = 0;
    end else begin
      bit do_push, do_pop, wrong;
      do_push = pred_valid && (mq.size() < DEPTH);
      do_pop  = res_valid && (mq.size() > 0);
      if (CNT_EN && exp_mis && exp_cnt < CMAX) exp_cnt++;
      wrong = 0;
      if (do_pop) wrong = (res_taken != mq[0]);
      exp_update = do_pop;
      exp_taken  = do_pop && res_taken;
      exp_mis    = wrong;
      if (res_valid && mq.size() == 0) exp_err = 1;
      if (wrong) mq.delete();
      else if (do_pop) void'(mq.pop_front());
      if (do_push && !wrong) mq.push_back(pred_taken);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready",  32'(pred_ready), 32'(mq.size() < DEPTH));
      check("m_empty",  32'(empty),      32'(mq.size() == 0));
      check("m_full",   32'(full),       32'(mq.size() == DEPTH));
      check("m_update", 32'(update),     32'(exp_update));
      check("m_taken",  32'(taken),      32'(exp_taken));
      check("m_mis",    32'(mispredict), 32'(exp_mis));
      check("m_err",    32'(res_err),    32'(exp_err));
      check("m_cnt",    32'(mispredict_count), 32'(exp_cnt));
    end
  end

  task automatic cyc(bit pv, bit pt, bit rv, bit rt);
    @(negedge clk);
    #2;
    pred_valid = pv;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    pred_valid = 0;
    res_valid  = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    pred_valid = 0;
    pred_taken = 0;
    res_valid  = 0;
    res_taken  = 0;
    reset = 1;
    #1;
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_ready", 32'(pred_ready), 1);
    check("rst_cnt",   32'(mispredict_count), 0);
    @(posedge clk);
    #1;
    reset = 0;
    chk_en = 1;

    // Fill to full, drop a fifth, resolve in order.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("fill_full",  32'(full), 1);
    check("fill_ready", 32'(pred_ready), 0);
    cyc(1, 0, 0, 0);
    check("drop_full", 32'(full), 1);
    cyc(0, 0, 1, 1);
    check("r0_taken", 32'(taken), 1);
    check("r0_upd",   32'(update), 1);
    cyc(0, 0, 1, 0);
    check("r1_taken", 32'(taken), 0);
    check("r1_mis",   32'(mispredict), 0);
    cyc(0, 0, 1, 1);
    check("r2_taken", 32'(taken), 1);
    cyc(0, 0, 1, 1);
    check("r3_taken", 32'(taken), 1);
    check("r3_empty", 32'(empty), 1);

    // Single correct resolve.
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 1);
    check("c_upd",   32'(update), 1);
    check("c_taken", 32'(taken), 1);
    check("c_mis",   32'(mispredict), 0);
    check("c_empty", 32'(empty), 1);

    // Mispredict flushes queue and same-cycle push.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    check("x_mis",   32'(mispredict), 1);
    check("x_taken", 32'(taken), 0);
    check("x_empty", 32'(empty), 1);
    cyc(0, 0, 0, 0);
    check("x_cnt", 32'(mispredict_count), CNT_ENn(1));

    // Resolve on empty queue: sticky error.
    do_reset();
    cyc(0, 0, 1, 1);
    check("e_upd", 32'(update), 0);
    check("e_err", 32'(res_err), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("e_hold", 32'(res_err), 1);
    do_reset();
    check("e_clr", 32'(res_err), 0);

    // Push plus correct pop at occupancy 2.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    check("s_taken", 32'(taken), 1);
    check("s_empty", 32'(empty), 0);
    check("s_full",  32'(full), 0);
    cyc(0, 0, 1, 0);
    check("s_o1", 32'(mispredict), 0);
    cyc(0, 0, 1, 1);
    check("s_o2", 32'(mispredict), 0);
    check("s_end", 32'(empty), 1);

    // Saturation with 300 mispredicts.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, 1, 0, 0);
      cyc(0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0);
    check("sat_cnt", 32'(mispredict_count), CNT_ENn(CMAX));

    // Reset right as a mispredict pulse is out.
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    reset = 1;
    #1;
    check("mr_mis",   32'(mispredict), 0);
    check("mr_upd",   32'(update), 0);
    check("mr_taken", 32'(taken), 0);
    check("mr_cnt",   32'(mispredict_count), 0);
    check("mr_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    reset = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit pv, pt, rv, rt;
      pv = ($urandom_range(0, 99) < 55);
      pt = $urandom_range(0, 1);
      rv = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 99) < 85) rt = mq[0];
      else rt = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(pv, pt, rv, rt);
      end
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [31:0] CNT_ENn(int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

endmodule
